lpif_x16_asym2_full_slave_gearbox: RTL and testbench
====================================================

// Module: lpif_x16_asym2_full_slave_gearbox
// PURPOSE
//  Full-rate slave end of the x16 asym2 LPIF link, facing the quarter-rate master packer.
//  TX: collects 4 consecutive full-rate dstrm beats into one 1124-bit txfifo word.
//  RX: pops 1124-bit rxfifo words and replays them as 4 consecutive ustrm beats.
//  Beat k occupies word bits [281*k +: 281].
//  Within a beat: state[0+:4], protid[4+:2], data[6+:256], dvalid[262], crc[263+:16],
//  crc_valid[279], valid[280].
// PARAMETERS
//  BEATS   4    beats per FIFO word (fixed ratio for asym2 quarter/full)
//  BEAT_W  281  packed bits per beat; word width = BEATS*BEAT_W = 1124
// PORTS
//  clk_wr                  in   1     full-rate clock; only clock
//  rst_wr_n                in   1     synchronous reset, active-low
//  tx_enable               in   1     1 = pack dstrm stream; 0 = hold TX phase at 0, no push
//  dstrm_state             in   4     per-beat fields ...
//  dstrm_protid            in   2
//  dstrm_data              in   256
//  dstrm_dvalid            in   1
//  dstrm_crc               in   16
//  dstrm_crc_valid         in   1
//  dstrm_valid             in   1
//  txfifo_downstream_data  out  1124  packed word
//  txfifo_downstream_push  out  1     1-cycle write strobe
//  txfifo_downstream_full  in   1     FIFO full
//  rxfifo_upstream_data    in   1124  show-ahead FIFO head; valid while !empty
//  rxfifo_upstream_empty   in   1     FIFO empty
//  rxfifo_upstream_pop     out  1     combinational pop; consumes head this cycle
//  ustrm_state/protid/data/dvalid/crc/crc_valid/valid  out  4/2/256/1/16/1/1  replayed beat
//  tx_overflow             out  1     sticky: push attempted while full
//  rx_underrun             out  1     sticky: FIFO empty when continuing a burst
// BEHAVIOUR
//  Reset (rst_wr_n=0 at posedge): all outputs 0, tx_phase=0, rx_busy=0, rx_phase=0.
//  Sticky flags clear only on reset.
//  TX packing:
//   - While tx_enable=1, every cycle is a beat; no dstrm qualification or backpressure.
//   - The beat is stored in slot tx_phase; tx_phase increments mod 4.
//   - On the cycle with tx_phase=3, the next edge registers txfifo_downstream_data
//     = {beat3, slot2, slot1, slot0} and pulses push for one cycle if !full.
//   - Latency: word and push appear 1 cycle after the 4th beat.
//   - If full on that cycle: no push, word dropped, tx_overflow<=1. Phase keeps running.
//   - tx_enable=0: tx_phase<=0, slots discarded, no push.
//     Re-enable starts a new word at slot 0, so a mid-word disable drops the partial word.
//   - txfifo_downstream_data holds its last value between pushes.
//  RX replay, FSM IDLE/REPLAY (rx_busy), rx_phase = slice currently on ustrm:
//   - pop = !empty && (!rx_busy || rx_phase==3).
//   - On pop: word_q<=head, ustrm<=slice0, rx_phase<=0, rx_busy<=1.
//   - REPLAY with rx_phase<3: ustrm<=word_q slice rx_phase+1, rx_phase++.
//   - rx_phase==3 && !empty: pop. Back-to-back words give a gapless beat stream.
//   - rx_phase==3 && empty: ustrm<=all zero (idle, ustrm_valid=0), rx_busy<=0,
//     rx_underrun<=1. The IDLE-with-empty state never sets rx_underrun.
//   - Pop-to-first-beat latency: 1 cycle (ustrm registered).
//  TX and RX run independently; simultaneous push and pop are allowed.
//  Reset mid-word: partial TX word discarded, replaying RX word abandoned (no re-pop).
// TESTING
//  T1: tx_enable=1, beats with dstrm_data=A0..A3, full=0
//      -> one push, 1 cycle after A3; word[6+:256]=A0, word[849+:256]=A3.
//  T2: 12 continuous beats -> exactly 3 pushes, 4 cycles apart, in order.
//  T3: full=1 during the 2nd word's phase-3 cycle -> 2nd word not pushed, tx_overflow=1,
//      3rd word pushed on schedule.
//  T4: rxfifo holds W0,W1 (slice k data = 16*W+k) -> 8 consecutive ustrm beats,
//      ustrm_data = 0,1,2,3,16,17,18,19; pop high exactly 2 cycles; then ustrm zeroed and
//      rx_underrun=1.
//  T5: empty from reset for 20 cycles -> no pop, ustrm all 0, rx_underrun=0.
//  T6: rst_wr_n=0 after 2 TX beats and mid-RX replay -> all outputs 0 next cycle;
//      after release, TX restarts at slot 0 and RX re-pops the FIFO head.

Source files
------------

// File: rtl/lpif_x16_asym2_full_slave_gearbox.sv
// ---------------------------------------------------------------------------
// lpif_x16_asym2_full_slave_gearbox
//
// Full-rate slave end of the x16 asym2 LPIF link. It faces the quarter-rate
// master packer through a pair of FIFOs.
//
//   TX: four consecutive full-rate dstrm beats are collected and written as
//       one 1124-bit txfifo word. Beat k sits at word bits [281*k +: 281].
//   RX: 1124-bit rxfifo words are popped and replayed as four consecutive
//       ustrm beats. Back-to-back words give a gapless beat stream.
//
// Beat layout (281 bits):
//   state[0+:4] protid[4+:2] data[6+:256] dvalid[262] crc[263+:16]
//   crc_valid[279] valid[280]
//
// Ports
//   clk_wr                   full-rate clock (the only clock)
//   rst_wr_n                 synchronous reset, active-low
//   tx_enable                1 = every cycle is a beat; 0 = hold TX phase at 0
//   dstrm_*                  incoming beat fields
//   txfifo_downstream_data   packed TX word, held between pushes
//   txfifo_downstream_push   one-cycle write strobe
//   txfifo_downstream_full   TX FIFO full
//   rxfifo_upstream_data     show-ahead RX FIFO head
//   rxfifo_upstream_empty    RX FIFO empty
//   rxfifo_upstream_pop      combinational pop, consumes the head this cycle
//   ustrm_*                  replayed beat fields (registered)
//   tx_overflow              sticky: a word was completed while the FIFO was full
//   rx_underrun              sticky: the FIFO ran dry in the middle of a burst
// ---------------------------------------------------------------------------
module lpif_x16_asym2_full_slave_gearbox #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 281
) (
  input  logic                      clk_wr,
  input  logic                      rst_wr_n,

  input  logic                      tx_enable,
  input  logic [3:0]                dstrm_state,
  input  logic [1:0]                dstrm_protid,
  input  logic [255:0]              dstrm_data,
  input  logic                      dstrm_dvalid,
  input  logic [15:0]               dstrm_crc,
  input  logic                      dstrm_crc_valid,
  input  logic                      dstrm_valid,

  output logic [BEATS*BEAT_W-1:0]   txfifo_downstream_data,
  output logic                      txfifo_downstream_push,
  input  logic                      txfifo_downstream_full,

  input  logic [BEATS*BEAT_W-1:0]   rxfifo_upstream_data,
  input  logic                      rxfifo_upstream_empty,
  output logic                      rxfifo_upstream_pop,

  output logic [3:0]                ustrm_state,
  output logic [1:0]                ustrm_protid,
  output logic [255:0]              ustrm_data,
  output logic                      ustrm_dvalid,
  output logic [15:0]               ustrm_crc,
  output logic                      ustrm_crc_valid,
  output logic                      ustrm_valid,

  output logic                      tx_overflow,
  output logic                      rx_underrun
);

  localparam int WORD_W = BEATS * BEAT_W;
  localparam int PW     = $clog2(BEATS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BEATS - 1);

  // RX replay FSM states
  localparam logic [0:0] RX_IDLE   = 1'b0;
  localparam logic [0:0] RX_REPLAY = 1'b1;

  // Field offsets inside one beat
  localparam int OFF_STATE  = 0;
  localparam int OFF_PROTID = 4;
  localparam int OFF_DATA   = 6;
  localparam int OFF_DVALID = 262;
  localparam int OFF_CRC    = 263;
  localparam int OFF_CRCV   = 279;
  localparam int OFF_VALID  = 280;

  // -------------------------------------------------------------------------
  // TX packing
  // -------------------------------------------------------------------------
  logic [BEAT_W-1:0]            tx_beat;
  logic [PW-1:0]                tx_phase;
  // Only the first BEATS-1 beats need storage; the last beat goes straight
  // from the dstrm inputs into the outgoing word.
  logic [(BEATS-1)*BEAT_W-1:0]  tx_slots;

  assign tx_beat = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                    dstrm_data, dstrm_protid, dstrm_state};

  // A disabled cycle returns the phase to 0, which abandons any partial word:
  // stale slot contents are simply overwritten by the next word.
  // A word completed while the FIFO is full is dropped, but the phase keeps
  // running so later words stay aligned to the master's schedule.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      tx_phase               <= '0;
      tx_slots               <= '0;
      txfifo_downstream_data <= '0;
      txfifo_downstream_push <= 1'b0;
      tx_overflow            <= 1'b0;
    end else begin
      txfifo_downstream_push <= 1'b0;
      if (!tx_enable) begin
        tx_phase <= '0;
      end else if (tx_phase == PHASE_LAST) begin
        tx_phase <= '0;
        if (txfifo_downstream_full) begin
          tx_overflow <= 1'b1;
        end else begin
          txfifo_downstream_data <= {tx_beat, tx_slots};
          txfifo_downstream_push <= 1'b1;
        end
      end else begin
        tx_slots[int'(tx_phase)*BEAT_W +: BEAT_W] <= tx_beat;
        tx_phase <= tx_phase + PW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // RX replay
  // -------------------------------------------------------------------------
  logic [0:0]                   rx_state;
  logic                         rx_busy;
  logic [PW-1:0]                rx_phase;
  // Slice 0 is loaded straight into ustrm on the pop, so only the remaining
  // slices are kept. word_q slice j holds FIFO word slice j+1.
  logic [WORD_W-BEAT_W-1:0]     word_q;
  logic [BEAT_W-1:0]            ustrm_beat;

  assign rx_busy = (rx_state == RX_REPLAY);

  // Pop while idle, or on the last slice of a burst so the next word follows
  // without a gap. Gated by reset so the head survives a reset and is popped
  // again once reset is released.
  assign rxfifo_upstream_pop = rst_wr_n && !rxfifo_upstream_empty &&
                               (!rx_busy || (rx_phase == PHASE_LAST));

  // rx_phase tracks the slice currently presented on ustrm. Running out of
  // words at the end of a burst zeroes ustrm and flags an underrun; sitting
  // idle with an empty FIFO is normal and is not flagged.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      rx_state    <= RX_IDLE;
      rx_phase    <= '0;
      word_q      <= '0;
      ustrm_beat  <= '0;
      rx_underrun <= 1'b0;
    end else if (rxfifo_upstream_pop) begin
      word_q     <= rxfifo_upstream_data[WORD_W-1:BEAT_W];
      ustrm_beat <= rxfifo_upstream_data[BEAT_W-1:0];
      rx_phase   <= '0;
      rx_state   <= RX_REPLAY;
    end else if (rx_busy) begin
      if (rx_phase != PHASE_LAST) begin
        ustrm_beat <= word_q[int'(rx_phase)*BEAT_W +: BEAT_W];
        rx_phase   <= rx_phase + PW'(1);
      end else begin
        ustrm_beat  <= '0;
        rx_phase    <= '0;
        rx_state    <= RX_IDLE;
        rx_underrun <= 1'b1;
      end
    end
  end

  assign ustrm_state     = ustrm_beat[OFF_STATE  +: 4];
  assign ustrm_protid    = ustrm_beat[OFF_PROTID +: 2];
  assign ustrm_data      = ustrm_beat[OFF_DATA   +: 256];
  assign ustrm_dvalid    = ustrm_beat[OFF_DVALID];
  assign ustrm_crc       = ustrm_beat[OFF_CRC    +: 16];
  assign ustrm_crc_valid = ustrm_beat[OFF_CRCV];
  assign ustrm_valid     = ustrm_beat[OFF_VALID];

endmodule

// File: tb/tb_lpif_x16_asym2_full_slave_gearbox.sv
// ---------------------------------------------------------------------------
// tb_lpif_x16_asym2_full_slave_gearbox
//
// Directed bench for the full-rate slave gearbox. Expected TX words and RX
// beats are pushed into scoreboard queues when stimulus is driven and popped
// by a negedge monitor when the DUT produces them. A small FIFO model feeds
// the RX side and honours the DUT's pop.
// ---------------------------------------------------------------------------
module tb_lpif_x16_asym2_full_slave_gearbox;

  localparam int BW = 281;
  localparam int WW = 4 * BW;

  logic            clk_wr = 1'b0;
  logic            rst_wr_n;
  logic            tx_enable;
  logic [3:0]      dstrm_state;
  logic [1:0]      dstrm_protid;
  logic [255:0]    dstrm_data;
  logic            dstrm_dvalid;
  logic [15:0]     dstrm_crc;
  logic            dstrm_crc_valid;
  logic            dstrm_valid;
  logic [WW-1:0]   txfifo_downstream_data;
  logic            txfifo_downstream_push;
  logic            txfifo_downstream_full;
  logic [WW-1:0]   rxfifo_upstream_data;
  logic            rxfifo_upstream_empty;
  logic            rxfifo_upstream_pop;
  logic [3:0]      ustrm_state;
  logic [1:0]      ustrm_protid;
  logic [255:0]    ustrm_data;
  logic            ustrm_dvalid;
  logic [15:0]     ustrm_crc;
  logic            ustrm_crc_valid;
  logic            ustrm_valid;
  logic            tx_overflow;
  logic            rx_underrun;

  lpif_x16_asym2_full_slave_gearbox dut (
    .clk_wr                 (clk_wr),
    .rst_wr_n               (rst_wr_n),
    .tx_enable              (tx_enable),
    .dstrm_state            (dstrm_state),
    .dstrm_protid           (dstrm_protid),
    .dstrm_data             (dstrm_data),
    .dstrm_dvalid           (dstrm_dvalid),
    .dstrm_crc              (dstrm_crc),
    .dstrm_crc_valid        (dstrm_crc_valid),
    .dstrm_valid            (dstrm_valid),
    .txfifo_downstream_data (txfifo_downstream_data),
    .txfifo_downstream_push (txfifo_downstream_push),
    .txfifo_downstream_full (txfifo_downstream_full),
    .rxfifo_upstream_data   (rxfifo_upstream_data),
    .rxfifo_upstream_empty  (rxfifo_upstream_empty),
    .rxfifo_upstream_pop    (rxfifo_upstream_pop),
    .ustrm_state            (ustrm_state),
    .ustrm_protid           (ustrm_protid),
    .ustrm_data             (ustrm_data),
    .ustrm_dvalid           (ustrm_dvalid),
    .ustrm_crc              (ustrm_crc),
    .ustrm_crc_valid        (ustrm_crc_valid),
    .ustrm_valid            (ustrm_valid),
    .tx_overflow            (tx_overflow),
    .rx_underrun            (rx_underrun)
  );

  always #5 clk_wr = ~clk_wr;

  int cyc = 0;
  always @(posedge clk_wr) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WW-1:0] word;
    int            cyc;
  } tx_exp_t;

  tx_exp_t        tx_q[$];
  logic [BW-1:0]  rx_exp[$];
  logic [WW-1:0]  fifo_q[$];

  int             mdl_phase = 0;
  logic [BW-1:0]  mdl_slot[4];
  int             push_count = 0;
  int             pop_count  = 0;
  logic [WW-1:0]  last_push_word = '0;
  logic [255:0]   a_data[4];
  tx_exp_t        mon_e;

  task automatic checkOutput(input string tag, input logic [BW-1:0] obs,
                             input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input logic [3:0] st, input logic [1:0] pid,
                                            input logic [255:0] d, input logic dv,
                                            input logic [15:0] crc, input logic cv,
                                            input logic v);
    return {v, cv, crc, dv, d, pid, st};
  endfunction

  function automatic logic [BW-1:0] rand_beat(input logic [255:0] d);
    return mk_beat(4'($urandom), 2'($urandom), d, 1'($urandom), 16'($urandom),
                   1'($urandom), 1'b1);
  endfunction

  function automatic logic [BW-1:0] ustrm_beat();
    return {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
            ustrm_data, ustrm_protid, ustrm_state};
  endfunction

  task automatic drive_fifo();
    rxfifo_upstream_empty = (fifo_q.size() == 0);
    rxfifo_upstream_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // Word w carries data 16*w+k in slice k; every slice is a valid beat.
  task automatic load_word(input int w);
    logic [WW-1:0] word;
    for (int k = 0; k < 4; k++) begin
      word[k*BW +: BW] = mk_beat(4'(k), 2'(k), 256'(16*w + k), 1'b1,
                                 16'(16'hC000 + 16*w + k), 1'b1, 1'b1);
      rx_exp.push_back(word[k*BW +: BW]);
    end
    fifo_q.push_back(word);
    drive_fifo();
  endtask

  // One TX cycle: drive the beat and advance the packing model.
  task automatic applyStimulus(input logic en, input logic full, input logic [BW-1:0] beat);
    tx_exp_t e;
    @(posedge clk_wr);
    #1;
    tx_enable              = en;
    txfifo_downstream_full = full;
    {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
     dstrm_data, dstrm_protid, dstrm_state} = beat;
    if (!en) begin
      mdl_phase = 0;
    end else begin
      mdl_slot[mdl_phase] = beat;
      if (mdl_phase == 3 && !full) begin
        e.word = {mdl_slot[3], mdl_slot[2], mdl_slot[1], mdl_slot[0]};
        e.cyc  = cyc + 1;
        tx_q.push_back(e);
      end
      mdl_phase = (mdl_phase + 1) % 4;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    checkOutput({pfx, "_push"}, BW'(txfifo_downstream_push), '0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("%s_txdata%0d", pfx, k), txfifo_downstream_data[k*BW +: BW], '0);
    checkOutput({pfx, "_ustrm"}, ustrm_beat(), '0);
    checkOutput({pfx, "_overflow"}, BW'(tx_overflow), '0);
    checkOutput({pfx, "_underrun"}, BW'(rx_underrun), '0);
    checkOutput({pfx, "_pop"}, BW'(rxfifo_upstream_pop), '0);
  endtask

  // RX FIFO model: the pop seen just before the edge consumes the head.
  always @(posedge clk_wr) begin
    logic taken;
    logic was_empty;
    taken     = rxfifo_upstream_pop;
    was_empty = rxfifo_upstream_empty;
    #1;
    if (taken === 1'b1) begin
      pop_count++;
      if (was_empty === 1'b1)
        checkOutput("rx_pop_while_empty", BW'(taken), '0);
      if (fifo_q.size() > 0)
        void'(fifo_q.pop_front());
      drive_fifo();
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk_wr) begin
    if (txfifo_downstream_push === 1'b1) begin
      push_count++;
      last_push_word = txfifo_downstream_data;
      if (tx_q.size() == 0) begin
        checkOutput("tx_unexpected_push", BW'(txfifo_downstream_push), '0);
      end else begin
        mon_e = tx_q.pop_front();
        for (int k = 0; k < 4; k++)
          checkOutput($sformatf("tx_word_slice%0d", k),
                      txfifo_downstream_data[k*BW +: BW], mon_e.word[k*BW +: BW]);
        checkOutput("tx_push_cycle", BW'(cyc), BW'(mon_e.cyc));
      end
    end
    if (ustrm_valid === 1'b1) begin
      if (rx_exp.size() == 0)
        checkOutput("rx_unexpected_beat", BW'(ustrm_valid), '0);
      else
        checkOutput("rx_beat", ustrm_beat(), rx_exp.pop_front());
    end
  end

  initial begin
    rst_wr_n               = 1'b0;
    tx_enable              = 1'b0;
    txfifo_downstream_full = 1'b0;
    {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
     dstrm_data, dstrm_protid, dstrm_state} = '0;
    drive_fifo();
    for (int k = 0; k < 4; k++) a_data[k] = {8{32'hA0A0_0000 + 32'(k)}};

    // Reset state
    repeat (2) @(posedge clk_wr);
    @(negedge clk_wr);
    check_all_zero("reset");
    @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;

    // T5: empty FIFO from reset, nothing happens on RX
    repeat (20) applyStimulus(1'b0, 1'b0, '0);
    @(negedge clk_wr);
    checkOutput("t5_pop_count", BW'(pop_count), '0);
    checkOutput("t5_ustrm_zero", ustrm_beat(), '0);
    checkOutput("t5_underrun", BW'(rx_underrun), '0);

    // T1: single word A0..A3
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, rand_beat(a_data[k]));
    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("t1_push_count", BW'(push_count), BW'(1));
    checkOutput("t1_word_a0", BW'(last_push_word[6 +: 256]), BW'(a_data[0]));
    checkOutput("t1_word_a3", BW'(last_push_word[849 +: 256]), BW'(a_data[3]));

    // T2: 12 continuous beats -> 3 words, 4 cycles apart
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, rand_beat(256'($urandom)));
    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("t2_push_count", BW'(push_count), BW'(4));
    checkOutput("t2_overflow", BW'(tx_overflow), '0);

    // T3: FIFO full on the second word's last beat
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, (i == 7), rand_beat(256'($urandom)));
    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("t3_push_count", BW'(push_count), BW'(6));
    checkOutput("t3_overflow", BW'(tx_overflow), BW'(1));

    // T4: two words replayed back to back, then underrun
    applyStimulus(1'b0, 1'b0, '0);
    pop_count = 0;
    load_word(0);
    load_word(1);
    @(posedge clk_wr);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_wr);
      checkOutput($sformatf("t4_gapless%0d", i), BW'(ustrm_valid), BW'(1));
      checkOutput($sformatf("t4_data%0d", i), BW'(ustrm_data),
                  BW'((i / 4) * 16 + (i % 4)));
    end
    @(negedge clk_wr);
    checkOutput("t4_ustrm_zero", ustrm_beat(), '0);
    checkOutput("t4_underrun", BW'(rx_underrun), BW'(1));
    checkOutput("t4_pop_count", BW'(pop_count), BW'(2));

    // T6: reset after two TX beats and in the middle of an RX replay
    applyStimulus(1'b1, 1'b0, rand_beat(256'($urandom)));
    load_word(2);
    load_word(3);
    applyStimulus(1'b1, 1'b0, rand_beat(256'($urandom)));
    @(posedge clk_wr);
    #1;
    rst_wr_n  = 1'b0;
    tx_enable = 1'b0;
    @(posedge clk_wr);
    #1;
    // The replaying word is abandoned; what remains in the FIFO is expected next.
    tx_q.delete();
    mdl_phase = 0;
    rx_exp.delete();
    foreach (fifo_q[j])
      for (int k = 0; k < 4; k++) rx_exp.push_back(fifo_q[j][k*BW +: BW]);
    @(negedge clk_wr);
    check_all_zero("t6_reset");
    @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, rand_beat(256'($urandom)));
    repeat (6) applyStimulus(1'b0, 1'b0, '0);
    @(negedge clk_wr);
    checkOutput("t6_push_count", BW'(push_count), BW'(7));
    checkOutput("t6_rx_drained", BW'(rx_exp.size()), '0);
    checkOutput("t6_fifo_drained", BW'(fifo_q.size()), '0);
    checkOutput("end_tx_queue", BW'(tx_q.size()), '0);
    checkOutput("t6_underrun", BW'(rx_underrun), BW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
